// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory responder for the single-cycle RISC-V core memory stage.
// Latency: handshake edge -> RESP after WAIT_CYCLES further edges; one request per WAIT_CYCLES+2 cycles.
// Backpressure: req_ready only in IDLE; requests in WAIT/RESP are ignored; responses cannot be stalled.
//
// Ports:
//   clk, reset           - single clock, asynchronous active-high reset
//   req_valid/req_ready  - request handshake (req_re load, req_we store, req_func3 size/sign)
//   req_addr, req_wdata  - byte address and right-aligned store data
//   rsp_valid            - one-cycle response strobe
//   rsp_rdata, rsp_err   - registered load data / error flag, held until the next response
//
// Build option: define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses with rsp_err.
// Without it, low address bits beyond the access size are ignored.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_re,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_cnt;
    logic          r_re, r_we;
    logic [2:0]    r_f3;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [0:DEPTH_WORDS-1];

    logic          w_hs, w_commit, w_do_write;
    logic          w_sel_re, w_sel_we;
    logic [2:0]    w_sel_f3;
    logic [AW+1:0] w_sel_addr;
    logic [31:0]   w_sel_wdata;
    logic [1:0]    w_size, w_lane;
    logic [AW-1:0] w_idx;
    logic          w_f3_ok, w_err;
    logic [3:0]    w_wmask;
    logic [31:0]   w_wdat, w_word, w_ldata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic          w_unused;

    // Address bits above the RAM size are ignored: accesses wrap modulo the RAM.
    assign w_unused = ^req_addr[31:AW+2];

    assign w_hs = req_valid && req_ready;

    // RESP is entered either straight from IDLE (WAIT_CYCLES==0) or from WAIT.
    assign w_commit = (w_next == S_RESP) && (r_state != S_RESP);

    // In IDLE the commit can coincide with the handshake, so use the live request.
    assign w_sel_re    = (r_state == S_IDLE) ? req_re    : r_re;
    assign w_sel_we    = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_sel_f3    = (r_state == S_IDLE) ? req_func3 : r_f3;
    assign w_sel_addr  = (r_state == S_IDLE) ? req_addr[AW+1:0] : r_addr;
    assign w_sel_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

    assign w_size = w_sel_f3[1:0];
    assign w_idx  = w_sel_addr[AW+1:2];

    // Valid loads: 000,001,010,100,101. Valid stores: 000,001,010. re&&we counts as a store.
    assign w_f3_ok = w_sel_we ? (!w_sel_f3[2] && (w_size != 2'b11))
                              : ((w_size != 2'b11) && (w_sel_f3 != 3'b110));

`ifdef DMEM_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((w_size == 2'b01) && w_sel_addr[0]) ||
                        ((w_size == 2'b10) && (w_sel_addr[1:0] != 2'b00));
    assign w_err = (w_sel_re || w_sel_we) && (!w_f3_ok || w_misalign);
`else
    assign w_err = (w_sel_re || w_sel_we) && !w_f3_ok;
`endif

    // Byte lane with alignment forced to the access size; misaligned accesses
    // never reach the RAM when the trap is enabled, so forcing is harmless there.
    always_comb begin
        case (w_size)
            2'b00:   w_lane = w_sel_addr[1:0];
            2'b01:   w_lane = {w_sel_addr[1], 1'b0};
            default: w_lane = 2'b00;
        endcase
    end

    always_comb begin
        case (w_size)
            2'b00: begin
                w_wmask = 4'b0001 << w_lane;
                w_wdat  = {4{w_sel_wdata[7:0]}};
            end
            2'b01: begin
                w_wmask = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdat  = {2{w_sel_wdata[15:0]}};
            end
            default: begin
                w_wmask = 4'b1111;
                w_wdat  = w_sel_wdata;
            end
        endcase
    end

    // Read happens before the write of the same edge; a store and a load are
    // never in the same transaction, so a later load sees the committed store.
    assign w_word = r_mem[w_idx];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        case (w_lane)
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    always_comb begin
        case (w_sel_f3)
            3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
            3'b100:  w_ldata = {24'd0, w_byte};
            3'b101:  w_ldata = {16'd0, w_half};
            default: w_ldata = w_word;
        endcase
    end

    // A reset arriving before the commit edge leaves the RAM untouched.
    assign w_do_write = w_commit && w_sel_we && !w_err && !reset;

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wmask[b]) r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
            end
        end
    end

    // State register, wait counter and request holding registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_hs) begin
                r_cnt   <= CNT_INIT;
                r_re    <= req_re;
                r_we    <= req_we;
                r_f3    <= req_func3;
                r_addr  <= req_addr[AW+1:0];
                r_wdata <= req_wdata;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_hs) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err   <= w_err;
            r_rdata <= (w_sel_re && !w_sel_we && !w_err) ? w_ldata : 32'd0;
        end
    end

    always_comb begin
        req_ready = (r_state == S_IDLE);
        rsp_valid = (r_state == S_RESP);
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized and directed checks of dmem_ctrl against a byte-array reference model.
// Latency: model predicts response WAIT_CYCLES edges after the handshake edge.
// Backpressure: driver waits (bounded) for req_ready before each request.
module tb_dmem_ctrl;
    localparam int W  = 1;
    localparam int DW = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_re = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_func3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_ctrl #(.DEPTH_WORDS(DW), .WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_re    (req_re),
        .req_we    (req_we),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model: little-endian byte array ----------------
    logic [7:0]  mb [0:4*DW-1];
    bit          m_busy = 1'b0;
    bit          m_rsp = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    logic        m_err = 1'b0;
    int          cyc = 0;
    int          m_due = 0;
    logic        l_re, l_we;
    logic [2:0]  l_f3;
    logic [31:0] l_addr, l_wd;

    task automatic model_exec(input logic re, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic e);
        int unsigned a;
        int          sz;
        logic [31:0] v;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        a  = addr % (4 * DW);
        rd = 32'd0;
        e  = 1'b0;
        if (we)      e = !(f3 inside {3'd0, 3'd1, 3'd2});
        else if (re) e = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((re || we) && !e && (a % sz != 0)) e = 1'b1;
`else
        a = a - (a % sz);
`endif
        if (we && !e) begin
            for (int i = 0; i < sz; i++) mb[a+i] = wd[8*i +: 8];
        end else if (re && !e) begin
            v = 32'd0;
            for (int i = 0; i < sz; i++) v = v | (32'(mb[a+i]) << (8*i));
            if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
            rd = v;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy  = 1'b0;
            m_rsp   = 1'b0;
            m_rdata = 32'd0;
            m_err   = 1'b0;
        end else begin
            cyc++;
            m_rsp = 1'b0;
            if (m_busy && cyc == m_due + 1) begin
                m_busy = 1'b0;
            end else if (!m_busy && req_valid) begin
                m_busy = 1'b1;
                m_due  = cyc + W;
                l_re = req_re; l_we = req_we; l_f3 = req_func3;
                l_addr = req_addr; l_wd = req_wdata;
            end
            if (m_busy && cyc == m_due) begin
                model_exec(l_re, l_we, l_f3, l_addr, l_wd, m_rdata, m_err);
                m_rsp = 1'b1;
            end
        end
    end

    // Every cycle: outputs against the model, sampled away from the rising edge.
    always @(negedge clk) begin
        check("req_ready", 32'(req_ready), 32'(!m_busy));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
        check("rsp_rdata", rsp_rdata, m_rdata);
        check("rsp_err",   32'(rsp_err), 32'(m_err));
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic re, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input bit hold,
                          output logic [31:0] rd, output logic e, output int lat);
        int n;
        rd = 32'd0; e = 1'b0; lat = -1;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_tests++; n_fail++;
            $display("FAIL ready_timeout: req_ready low for 50 cycles, expected high");
            return;
        end
        req_valid = 1'b1; req_re = re; req_we = we; req_func3 = f3;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        // lat = rising edges after the handshake edge until rsp_valid is seen
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            if (rsp_valid) begin
                rd = rsp_rdata; e = rsp_err; lat = n;
                break;
            end
        end
        req_valid = 1'b0;
        if (lat < 0) begin
            n_tests++; n_fail++;
            $display("FAIL rsp_timeout: no rsp_valid within 40 cycles, expected one");
        end
    endtask

    task automatic dchk(input string name, input logic re, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        e;
        int          lat;
        do_req(re, we, f3, addr, wd, 1'b0, rd, e, lat);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_err"}, 32'(e), 32'(exp_err));
        check({name, "_lat"}, 32'(lat), 32'(W));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          cnt;
        int          k;
        logic        rre, rwe;

        for (int i = 0; i < 4*DW; i++) mb[i] = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // preload the words used below (byte addresses 0x00..0x3F)
        for (int w = 0; w < 16; w++) do_req(1'b0, 1'b1, 3'b010, 32'(w*4), $urandom, 1'b0, rd, e, lat);

        dchk("sw10",  1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        dchk("lw10",  1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        dchk("lb13",  1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        dchk("lbu13", 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        dchk("lh10",  1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
        dchk("lhu12", 1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
        dchk("sb11",  1'b0, 1'b1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 1'b0);
        dchk("lw10b", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);
        dchk("wrap",  1'b1, 1'b0, 3'b010, 32'h1010, 32'h0, 32'hDEADAAEF, 1'b0);
        dchk("inv011", 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
        dchk("rewe",  1'b1, 1'b1, 3'b010, 32'h14, 32'h12345678, 32'h0, 1'b0);
        dchk("lw14",  1'b1, 1'b0, 3'b010, 32'h14, 32'h0, 32'h12345678, 1'b0);
        dchk("noop",  1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0);

        // req_valid held through WAIT/RESP: exactly one response
        do_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, rd, e, lat);
        check("hold_rdata", rd, 32'hDEADAAEF);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        check("hold_extra_rsp", 32'(cnt), 32'd0);

        // misalignment
        dchk("sw10c", 1'b0, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        dchk("sw12",  1'b0, 1'b1, 3'b010, 32'h12, 32'h4, 32'h0, 1'b1);
        dchk("lw12",  1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
        dchk("lw10c", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);
`else
        dchk("sw12",  1'b0, 1'b1, 3'b010, 32'h12, 32'h4, 32'h0, 1'b0);
        dchk("lw12",  1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 32'h4, 1'b0);
        dchk("lh13",  1'b1, 1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b0);
`endif

        // reset during WAIT aborts the store
        dchk("sw20", 1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_re = 1'b0; req_we = 1'b1; req_func3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'h55;
        @(posedge clk);
        #2;
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dchk("lw20", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344, 1'b0);

        // randomized traffic over words 0..15 with random upper address bits
        for (int t = 0; t < 300; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            k = $urandom_range(0, 9);
            rre = (k <= 3) || (k == 8);
            rwe = (k >= 4 && k <= 8);
            do_req(rre, rwe, 3'($urandom_range(0, 7)),
                   ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63)),
                   $urandom, ($urandom_range(0, 3) == 0), rd, e, lat);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
